// File: rtl/param_slow_memory.sv
// param_slow_memory: line-organised memory model with a fixed access latency.
// Every request passes IDLE -> WAIT (LATENCY cycles) -> BUBBLE (access) -> READY,
// and completes with a one-cycle mem_ready pulse. All state moves on the
// falling edge of clk.
//
// Ports
//   clk        single clock, falling-edge active
//   rst_n      asynchronous active-low reset (memory contents are kept)
//   mem_read   read request, held by the master until mem_ready
//   mem_write  write request, held by the master until mem_ready
//   mem_addr   line address (ADDR_W bits)
//   mem_wdata  write line, word k at [k*WORD_W +: WORD_W]
//   mem_wmask  per-word write enable
//   mem_rdata  registered read line, holds until the next completed read
//   mem_ready  registered one-cycle completion pulse
//   mem_err    registered error flag, meaningful while mem_ready=1
//
// LATENCY must lie in 1..255 (the wait counter is 8 bits wide).
module param_slow_memory #(
  parameter int unsigned MEM_NUM = 1024,
  parameter int unsigned WORD_W  = 32,
  parameter int unsigned WORDS   = 4,
  parameter int unsigned ADDR_W  = 28,
  parameter int unsigned LATENCY = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     mem_read,
  input  logic                     mem_write,
  input  logic [ADDR_W-1:0]        mem_addr,
  input  logic [WORD_W*WORDS-1:0]  mem_wdata,
  input  logic [WORDS-1:0]         mem_wmask,
  output logic [WORD_W*WORDS-1:0]  mem_rdata,
  output logic                     mem_ready,
  output logic                     mem_err
);

  localparam int unsigned MEM_WIDTH = WORD_W * WORDS;
  localparam int unsigned IDX_W     = (MEM_NUM > 1) ? $clog2(MEM_NUM) : 1;
  localparam int unsigned CNT_W     = 8;

  // One captured request: used both for the per-edge input copy and for the
  // transaction frozen on the IDLE-to-WAIT edge.
  typedef struct packed {
    logic                 rd;
    logic                 wr;
    logic [ADDR_W-1:0]    addr;
    logic [MEM_WIDTH-1:0] wdata;
    logic [WORDS-1:0]     mask;
  } req_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WAIT   = 2'd1,
    BUBBLE = 2'd2,
    READY  = 2'd3
  } state_t;

  logic [MEM_WIDTH-1:0] mem [MEM_NUM];

  req_t                 req_q;
  req_t                 txn_q, txn_d;
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 ready_d;
  logic                 err_d;
  logic [MEM_WIDTH-1:0] rdata_d;

  logic                 addr_bad_c;
  logic                 conflict_c;
  logic                 txn_err_c;
  logic [IDX_W-1:0]     idx_c;
  logic [MEM_WIDTH-1:0] line_c;
  logic                 mem_we_c;

  // Input capture on every falling edge; all decisions use these copies.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q <= '0;
    end else begin
      req_q.rd    <= mem_read;
      req_q.wr    <= mem_write;
      req_q.addr  <= mem_addr;
      req_q.wdata <= mem_wdata;
      req_q.mask  <= mem_wmask;
    end
  end

  // Error classification of the frozen transaction.
  always_comb begin
    addr_bad_c = (64'(txn_q.addr) >= 64'(MEM_NUM));
    conflict_c = txn_q.rd & txn_q.wr;
    txn_err_c  = addr_bad_c | conflict_c;
    // Park the index at 0 for bad addresses so the array is never read out of range.
    idx_c      = addr_bad_c ? '0 : IDX_W'(txn_q.addr);
    line_c     = mem[idx_c];
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    txn_d    = txn_q;
    ready_d  = 1'b0;
    err_d    = 1'b0;
    rdata_d  = mem_rdata;
    mem_we_c = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_q.rd || req_q.wr) begin
          state_d = WAIT;
          cnt_d   = CNT_W'(LATENCY - 1);
          txn_d   = req_q;
        end
      end

      WAIT: begin
        // Counter starts at LATENCY-1, so WAIT spans exactly LATENCY cycles.
        if (cnt_q == '0) begin
          state_d = BUBBLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      BUBBLE: begin
        state_d  = READY;
        ready_d  = 1'b1;
        err_d    = txn_err_c;
        mem_we_c = txn_q.wr & ~txn_err_c;
        // Writes leave mem_rdata alone; any failed read returns zero.
        if (txn_q.rd) begin
          rdata_d = txn_err_c ? '0 : line_c;
        end
      end

      READY: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Control and output registers.
  always_ff @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      txn_q     <= '0;
      mem_ready <= 1'b0;
      mem_err   <= 1'b0;
      mem_rdata <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      txn_q     <= txn_d;
      mem_ready <= ready_d;
      mem_err   <= err_d;
      mem_rdata <= rdata_d;
    end
  end

  // Storage array: no reset, masked per-word update in BUBBLE only.
  always_ff @(negedge clk) begin
    for (int k = 0; k < int'(WORDS); k++) begin
      if (mem_we_c && txn_q.mask[k]) begin
        mem[idx_c][k*WORD_W +: WORD_W] <= txn_q.wdata[k*WORD_W +: WORD_W];
      end
    end
  end

endmodule

// File: tb/tb_param_slow_memory.sv
// Directed bench for param_slow_memory: a vector table of single transactions
// followed by hand-written reset-abort, request-change and back-to-back sequences.
module tb_param_slow_memory;

  localparam int unsigned MEM_NUM = 16;
  localparam int unsigned WORD_W  = 32;
  localparam int unsigned WORDS   = 4;
  localparam int unsigned ADDR_W  = 28;
  localparam int unsigned LATENCY = 5;
  localparam int unsigned MW      = WORD_W * WORDS;
  localparam int          EXP_CYC = LATENCY + 3;
  localparam int          BUDGET  = 40;

  localparam logic [MW-1:0] L3A  = 128'h00000044_00000033_00000022_00000011;
  localparam logic [MW-1:0] L3B  = 128'h00000044_00000033_000000AA_00000011;
  localparam logic [MW-1:0] M2   = 128'hDEAD0003_DEAD0002_000000AA_DEAD0000;
  localparam logic [MW-1:0] L0   = 128'h00000004_00000003_00000002_00000001;
  localparam logic [MW-1:0] L1   = 128'h10000004_10000003_10000002_10000001;
  localparam logic [MW-1:0] L2   = 128'h20000004_20000003_20000002_20000001;
  localparam logic [MW-1:0] L5   = 128'h55555555_55555555_55555555_55555555;
  localparam logic [MW-1:0] L15  = 128'hF00D0004_F00D0003_F00D0002_F00D0001;
  localparam logic [MW-1:0] ONES = '1;

  logic              clk;
  logic              rst_n;
  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [MW-1:0]     mem_wdata;
  logic [WORDS-1:0]  mem_wmask;
  logic [MW-1:0]     mem_rdata;
  logic              mem_ready;
  logic              mem_err;

  int n_checks = 0;
  int n_pass   = 0;
  int pulses   = 0;

  param_slow_memory #(
    .MEM_NUM(MEM_NUM), .WORD_W(WORD_W), .WORDS(WORDS),
    .ADDR_W(ADDR_W), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .mem_err(mem_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (mem_ready) pulses++;

  typedef struct {
    logic              rd;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [MW-1:0]     wdata;
    logic [WORDS-1:0]  mask;
    logic [MW-1:0]     exp_rdata;
    logic              exp_err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [MW-1:0] got, input logic [MW-1:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic drive(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [MW-1:0] wdata, input logic [WORDS-1:0] mask);
    mem_read  = rd;
    mem_write = wr;
    mem_addr  = addr;
    mem_wdata = wdata;
    mem_wmask = mask;
  endtask

  // Called at a rising edge: presents the request and counts rising edges until
  // mem_ready is seen. The request stays asserted on return.
  task automatic issue(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                       input logic [MW-1:0] wdata, input logic [WORDS-1:0] mask,
                       output int cyc, output logic [MW-1:0] rdata, output logic err);
    drive(rd, wr, addr, wdata, mask);
    cyc = BUDGET + 1;
    for (int c = 1; c <= BUDGET; c++) begin
      @(posedge clk);
      if (mem_ready) begin
        cyc = c;
        break;
      end
    end
    if (cyc > BUDGET) $display("FAIL timeout: no mem_ready within %0d cycles", BUDGET);
    rdata = mem_rdata;
    err   = mem_err;
  endtask

  // Drop the request and confirm the pulse lasted one cycle and err cleared with it.
  task automatic idle(input string tag);
    drive(1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    check({tag, "_ready_low"}, MW'(mem_ready), '0);
    check({tag, "_err_low"}, MW'(mem_err), '0);
  endtask

  task automatic add(input logic rd, input logic wr, input logic [ADDR_W-1:0] addr,
                     input logic [MW-1:0] wdata, input logic [WORDS-1:0] mask,
                     input logic [MW-1:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.rd = rd; v.wr = wr; v.addr = addr; v.wdata = wdata; v.mask = mask;
    v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endtask

  initial begin
    int            cyc;
    logic [MW-1:0] rd_data;
    logic          err;
    int            p0;

    //   rd  wr  addr           wdata  mask     exp_rdata  exp_err
    add(1'b0, 1'b1, 28'd3,      L3A,  4'b1111, '0,  1'b0);
    add(1'b1, 1'b0, 28'd3,      '0,   4'b0000, L3A, 1'b0);
    add(1'b0, 1'b1, 28'd3,      M2,   4'b0010, L3A, 1'b0);
    add(1'b1, 1'b0, 28'd3,      '0,   4'b0000, L3B, 1'b0);
    add(1'b1, 1'b0, 28'd16,     '0,   4'b0000, '0,  1'b1);
    add(1'b1, 1'b0, 28'd3,      '0,   4'b0000, L3B, 1'b0);
    add(1'b1, 1'b1, 28'd3,      ONES, 4'b1111, '0,  1'b1);
    add(1'b1, 1'b0, 28'd3,      '0,   4'b0000, L3B, 1'b0);
    add(1'b0, 1'b1, 28'd3,      ONES, 4'b0000, L3B, 1'b0);
    add(1'b1, 1'b0, 28'd3,      '0,   4'b0000, L3B, 1'b0);
    add(1'b0, 1'b1, 28'd0,      L0,   4'b1111, L3B, 1'b0);
    add(1'b0, 1'b1, 28'd16,     ONES, 4'b1111, L3B, 1'b1);
    add(1'b1, 1'b0, 28'd0,      '0,   4'b0000, L0,  1'b0);
    add(1'b0, 1'b1, 28'd1,      L1,   4'b1111, L0,  1'b0);
    add(1'b0, 1'b1, 28'd2,      L2,   4'b1111, L0,  1'b0);
    add(1'b0, 1'b1, 28'd5,      L5,   4'b1111, L0,  1'b0);
    add(1'b0, 1'b1, 28'd15,     L15,  4'b1111, L0,  1'b0);
    add(1'b1, 1'b0, 28'd15,     '0,   4'b0000, L15, 1'b0);
    add(1'b1, 1'b0, 28'hFFFFFFF,'0,   4'b0000, '0,  1'b1);
    add(1'b0, 1'b1, 28'h8000003,ONES, 4'b1111, '0,  1'b1);
    add(1'b1, 1'b0, 28'd3,      '0,   4'b0000, L3B, 1'b0);
    add(1'b1, 1'b0, 28'd1,      '0,   4'b0000, L1,  1'b0);

    rst_n = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    #1;
    check("reset_ready", MW'(mem_ready), '0);
    check("reset_err", MW'(mem_err), '0);
    check("reset_rdata", mem_rdata, '0);
    repeat (2) @(posedge clk);
    rst_n = 1'b1;
    @(posedge clk);

    foreach (vecs[i]) begin
      issue(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].mask, cyc, rd_data, err);
      check($sformatf("v%0d_latency", i), MW'(cyc), MW'(EXP_CYC));
      check($sformatf("v%0d_err", i), MW'(err), MW'(vecs[i].exp_err));
      check($sformatf("v%0d_rdata", i), rd_data, vecs[i].exp_rdata);
      idle($sformatf("v%0d", i));
    end

    // Request changes during WAIT must not affect the captured transaction.
    drive(1'b1, 1'b0, 28'd3, '0, '0);
    repeat (2) @(posedge clk);
    drive(1'b1, 1'b1, 28'd0, ONES, 4'b1111);
    cyc = BUDGET + 1;
    for (int c = 3; c <= BUDGET; c++) begin
      @(posedge clk);
      if (mem_ready) begin
        cyc = c;
        break;
      end
    end
    if (cyc > BUDGET) $display("FAIL timeout: no mem_ready within %0d cycles", BUDGET);
    check("chg_latency", MW'(cyc), MW'(EXP_CYC));
    check("chg_err", MW'(mem_err), '0);
    check("chg_rdata", mem_rdata, L3B);
    idle("chg");
    issue(1'b1, 1'b0, 28'd0, '0, '0, cyc, rd_data, err);
    check("chg_addr0_kept", rd_data, L0);
    idle("chg2");

    // Reset during WAIT of a write to addr 5 aborts it: no write, no pulse.
    drive(1'b0, 1'b1, 28'd5, ONES, 4'b1111);
    repeat (3) @(posedge clk);
    p0 = pulses;
    #2 rst_n = 1'b0;
    #1;
    check("rst_ready", MW'(mem_ready), '0);
    check("rst_err", MW'(mem_err), '0);
    check("rst_rdata", mem_rdata, '0);
    repeat (3) @(posedge clk);
    drive(1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    rst_n = 1'b1;
    repeat (12) @(posedge clk);
    check("rst_no_pulse", MW'(pulses), MW'(p0));
    issue(1'b1, 1'b0, 28'd5, '0, '0, cyc, rd_data, err);
    check("rst_latency", MW'(cyc), MW'(EXP_CYC));
    check("rst_addr5", rd_data, L5);
    idle("rst");

    // Back-to-back reads: next request replaces the old one right after mem_ready.
    issue(1'b1, 1'b0, 28'd0, '0, '0, cyc, rd_data, err);
    check("b2b0_latency", MW'(cyc), MW'(EXP_CYC));
    check("b2b0_rdata", rd_data, L0);
    issue(1'b1, 1'b0, 28'd1, '0, '0, cyc, rd_data, err);
    check("b2b1_gap", MW'(cyc), MW'(EXP_CYC));
    check("b2b1_rdata", rd_data, L1);
    issue(1'b1, 1'b0, 28'd2, '0, '0, cyc, rd_data, err);
    check("b2b2_gap", MW'(cyc), MW'(EXP_CYC));
    check("b2b2_rdata", rd_data, L2);
    check("b2b2_err", MW'(err), '0);
    idle("b2b");
    p0 = pulses;
    repeat (12) @(posedge clk);
    check("b2b_no_spurious", MW'(pulses), MW'(p0));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/param_slow_memory.md
PARAM_SLOW_MEMORY -- requirements
Module: param_slow_memory

Interface
REQ-001 The block SHALL provide parameter MEM_NUM, default 1024, giving the number of memory lines.
REQ-002 The block SHALL provide parameter WORD_W, default 32, giving the word width in bits.
REQ-003 The block SHALL provide parameter WORDS, default 4, giving words per line; MEM_WIDTH = WORD_W*WORDS.
REQ-004 The block SHALL provide parameter ADDR_W, default 28, giving the line-address width.
REQ-005 The block SHALL provide parameter LATENCY, default 5, giving WAIT-state cycles; legal range is 1..255.
REQ-006 The block SHALL have port clk, input, 1 bit: single clock; all state updates occur on its falling edge.
REQ-007 The block SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-008 The block SHALL have port mem_read, input, 1 bit: read request, held by the master until mem_ready is seen.
REQ-009 The block SHALL have port mem_write, input, 1 bit: write request, held by the master until mem_ready is seen.
REQ-010 The block SHALL have port mem_addr, input, ADDR_W bits: line address.
REQ-011 The block SHALL have port mem_wdata, input, MEM_WIDTH bits: write line; word k occupies bits [k*WORD_W +: WORD_W].
REQ-012 The block SHALL have port mem_wmask, input, WORDS bits: per-word write enable.
REQ-013 The block SHALL have port mem_rdata, output, MEM_WIDTH bits: registered read line.
REQ-014 The block SHALL have port mem_ready, output, 1 bit: registered one-cycle completion pulse.
REQ-015 The block SHALL have port mem_err, output, 1 bit: registered error flag, valid while mem_ready=1.

Function
REQ-016 The block SHALL register mem_read, mem_write, mem_addr, mem_wdata and mem_wmask on every falling clk edge; all decisions use the registered copies.
REQ-017 The FSM SHALL have exactly four states: IDLE, WAIT, BUBBLE and READY.
REQ-018 IDLE SHALL go to WAIT when registered read or write is 1 and load the latency counter with LATENCY-1; otherwise it SHALL stay in IDLE.
REQ-019 WAIT SHALL decrement the counter each cycle and go to BUBBLE when the counter is 0, so that WAIT lasts exactly LATENCY cycles; no # delays SHALL be used.
REQ-020 BUBBLE SHALL perform the access, drive mem_ready to 1 at the next edge and go to READY.
REQ-021 READY SHALL drive mem_ready to 0 at the next edge and return to IDLE.
REQ-022 With the request registered at falling edge N, mem_ready SHALL be 1 from edge N+LATENCY+2 to edge N+LATENCY+3, exactly one cycle.
REQ-023 A read (read=1, write=0, addr<MEM_NUM) SHALL load mem_rdata with the full line; mem_rdata SHALL hold that value until the next completed read.
REQ-024 A write (write=1, read=0, addr<MEM_NUM) SHALL update only the words whose mem_wmask bit is 1; the other words and mem_rdata SHALL be unchanged.
REQ-025 A write with mem_wmask=0 SHALL complete normally with no change to memory and mem_err=0.
REQ-026 read=1 and write=1 together SHALL complete with mem_ready and mem_err=1, leave memory unchanged and set mem_rdata to 0.
REQ-027 An address >= MEM_NUM SHALL complete with mem_ready and mem_err=1, leave memory unchanged and, for a read, set mem_rdata to 0.
REQ-028 mem_err SHALL be 0 on successful completions and SHALL return to 0 together with mem_ready.
REQ-029 Request changes during WAIT or BUBBLE SHALL be ignored; the access SHALL use the address, data and mask captured on the IDLE-to-WAIT edge.
REQ-030 The master SHALL deassert its request on the rising edge after it sees mem_ready, so that the return to IDLE does not start a spurious transaction.

Reset
REQ-031 rst_n=0 SHALL immediately force: state IDLE, counter 0, mem_ready 0, mem_err 0, mem_rdata 0 and all input registers 0.
REQ-032 Memory contents SHALL NOT be cleared by reset.
REQ-033 A reset asserted before the BUBBLE edge SHALL abort the transaction with no memory write and no mem_ready pulse.

Verification
REQ-034 Write addr 3, wdata words {D,C,B,A}={0x44,0x33,0x22,0x11}, mask 4'b1111, then read addr 3 -> mem_rdata = 0x00000044_00000033_00000022_00000011, mem_err=0.
REQ-035 With LATENCY=5 and the read registered at edge 10 -> mem_ready is 1 only between edges 17 and 18.
REQ-036 After REQ-034, write addr 3 with word 1 = 0xAA and mask 4'b0010, then read addr 3 -> only word 1 = 0xAA; other words unchanged.
REQ-037 Read with addr = MEM_NUM -> mem_ready pulse, mem_err=1, mem_rdata=0; read=1 and write=1 together -> mem_err=1, memory unchanged.
REQ-038 Drive rst_n low during WAIT of a write to addr 5, then release and read addr 5 -> pre-write contents returned, with no mem_ready pulse during the reset.
REQ-039 Run back-to-back reads to addrs 0, 1, 2 with the master deasserting the request one cycle after mem_ready -> three pulses, each LATENCY+3 cycles apart, with correct data.
